axis_pkt_gen: RTL and testbench

//  AXI4-Stream packet transmitter. Drives the s_axis input of AXI_DMA (or AXI_FIFO) in system benches and bring-up.

---
 rtl/axis_pkt_gen.sv | 139 +++++++++++++
 tb/tb_axis_pkt_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: emits pkt_num packets of pkt_len incrementing words
// starting at seed, honouring tready backpressure with optional idle gaps between packets.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int NUM_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [NUM_WIDTH-1:0]  pkt_num,
  input  logic [7:0]            gap,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [NUM_WIDTH-1:0]  num_reg, num_next;
  logic [7:0]            gap_reg, gap_next;
  logic [7:0]            gap_cnt_reg, gap_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic [NUM_WIDTH-1:0]  pkt_cnt_reg, pkt_cnt_next;
  logic                  tvalid_reg, tvalid_next;
  logic                  tlast_reg, tlast_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  accept;

  assign accept = tvalid_reg & m_axis_tready;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      num_reg      <= '0;
      gap_reg      <= '0;
      gap_cnt_reg  <= '0;
      data_reg     <= '0;
      beat_cnt_reg <= '0;
      pkt_cnt_reg  <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      num_reg      <= num_next;
      gap_reg      <= gap_next;
      gap_cnt_reg  <= gap_cnt_next;
      data_reg     <= data_next;
      beat_cnt_reg <= beat_cnt_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    num_next      = num_reg;
    gap_next      = gap_reg;
    gap_cnt_next  = gap_cnt_reg;
    data_next     = data_reg;
    beat_cnt_next = beat_cnt_reg;
    pkt_cnt_next  = pkt_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next      = pkt_len;
          num_next      = pkt_num;
          gap_next      = gap;
          data_next     = seed;
          beat_cnt_next = '0;
          pkt_cnt_next  = '0;
          state_next    = (pkt_len != '0 && pkt_num != '0) ? SEND : FIN;
        end
      end
      SEND: begin
        if (accept) begin
          data_next = data_reg + DATA_WIDTH'(1);
          if (tlast_reg) begin
            beat_cnt_next = '0;
            pkt_cnt_next  = pkt_cnt_reg + NUM_WIDTH'(1);
            if (pkt_cnt_reg + NUM_WIDTH'(1) == num_reg) begin
              state_next = FIN;
            end else if (gap_reg != 8'd0) begin
              gap_cnt_next = gap_reg;
              state_next   = GAP;
            end
          end else begin
            beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        // The GAP state is occupied for exactly gap_reg cycles.
        if (gap_cnt_reg == 8'd1) begin
          state_next = SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state will present.
    tvalid_next = (state_next == SEND);
    busy_next   = (state_next == SEND) || (state_next == GAP);
    done_next   = (state_next == FIN);
    tlast_next  = (state_next == SEND) && (beat_cnt_next == len_next - LEN_WIDTH'(1));
  end

  assign m_axis_tdata  = data_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: table of runs checked beat-by-beat against a
// scoreboard, plus hand-written reset and idle sequences.
module tb_axis_pkt_gen;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_num = '0;
  logic [7:0]  gap = '0;
  logic [31:0] seed = '0;
  logic        busy;
  logic        done;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] seed;
    logic [15:0] len;
    logic [15:0] num;
    logic [7:0]  gap;
    bit          rnd;
    int          poke_cyc;
    int          exp_beats;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  always #5 ACLK = ~ACLK;

  axis_pkt_gen #(.DATA_WIDTH(32), .LEN_WIDTH(16), .NUM_WIDTH(16)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .start         (start),
    .pkt_len       (pkt_len),
    .pkt_num       (pkt_num),
    .gap           (gap),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int beat = 0;
    int cyc = 0;
    int done_cnt = 0;
    int gap_run = 0;
    int done_cyc = -1;
    int last_acc_cyc = -1;
    int l;
    bit stalled = 1'b0;
    bit finished = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [31:0] last_data = '0;
    logic [31:0] exp_data;
    l = (v.len == 16'd0) ? 1 : int'(v.len);

    @(negedge ACLK);
    seed = v.seed; pkt_len = v.len; pkt_num = v.num; gap = v.gap; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    chk("first_valid", 32'(m_axis_tvalid), 32'(v.exp_beats > 0));
    chk("first_busy", 32'(busy), 32'(v.exp_beats > 0));

    while (!finished && cyc < 2000) begin
      if (stalled) begin
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall_data", m_axis_tdata, held_data);
        chk("stall_last", 32'(m_axis_tlast), 32'(held_last));
      end
      stalled = 1'b0;
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        exp_data = v.seed + 32'(beat);
        chk("beat_data", m_axis_tdata, exp_data);
        chk("beat_last", 32'(m_axis_tlast), 32'((beat % l) == l - 1));
        if (beat > 0 && (beat % l) == 0) chk("gap_cycles", 32'(gap_run), 32'(v.gap));
        gap_run = 0;
        last_data = m_axis_tdata;
        last_acc_cyc = cyc;
        beat++;
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        held_data = m_axis_tdata;
        held_last = m_axis_tlast;
      end else if (busy) begin
        gap_run++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("done_busy", 32'(busy), 32'd0);
      end
      if (done_cyc >= 0 && cyc > done_cyc) chk("idle_valid", 32'(m_axis_tvalid), 32'd0);
      if (done_cyc >= 0 && cyc >= done_cyc + 4) finished = 1'b1;
      if (cyc == v.poke_cyc) begin
        start = 1'b1; pkt_len = 16'd5; pkt_num = 16'd1; gap = 8'd0; seed = 32'hDEAD;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge ACLK);
    end
    start = 1'b0;
    m_axis_tready = 1'b0;

    chk("run_ended", 32'(finished), 32'd1);
    chk("beat_count", 32'(beat), 32'(v.exp_beats));
    chk("done_count", 32'(done_cnt), 32'd1);
    if (v.exp_beats > 0) begin
      chk("last_data", last_data, v.exp_last);
      chk("done_latency", 32'(done_cyc - last_acc_cyc), 32'd1);
    end else begin
      chk("done_latency", 32'(done_cyc), 32'd0);
    end
    $display("vec %0d: seed=0x%08h len=%0d num=%0d gap=%0d beats=%0d done_cnt=%0d",
             id, v.seed, v.len, v.num, v.gap, beat, done_cnt);
  endtask

  initial begin
    int  done_seen;
    int  valid_seen;
    //        seed          len    num    gap   rnd  poke exp  last
    vecs[0] = '{32'h00000010, 16'd4, 16'd1, 8'd0, 1'b0, -1, 4,  32'h00000013};
    vecs[1] = '{32'h00000100, 16'd3, 16'd3, 8'd2, 1'b0, -1, 9,  32'h00000108};
    vecs[2] = '{32'h00002000, 16'd8, 16'd2, 8'd1, 1'b1, -1, 16, 32'h0000200F};
    vecs[3] = '{32'hFFFFFFFE, 16'd4, 16'd1, 8'd0, 1'b0, -1, 4,  32'h00000001};
    vecs[4] = '{32'h00000055, 16'd0, 16'd3, 8'd0, 1'b0, 0,  0,  32'h00000000};
    vecs[5] = '{32'h00000070, 16'd3, 16'd2, 8'd1, 1'b0, 2,  6,  32'h00000075};
    vecs[6] = '{32'h000000A0, 16'd1, 16'd3, 8'd0, 1'b0, -1, 3,  32'h000000A2};
    vecs[7] = '{32'h00000030, 16'd2, 16'd0, 8'd0, 1'b0, -1, 0,  32'h00000000};

    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_last", 32'(m_axis_tlast), 32'd0);
    chk("rst_data", m_axis_tdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    ARESETn = 1'b1;
    $display("reset: valid=%0b data=0x%08h busy=%0b done=%0b", m_axis_tvalid, m_axis_tdata, busy, done);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort a 10-beat run while its fifth beat is on the bus.
    @(negedge ACLK);
    seed = 32'h400; pkt_len = 16'd10; pkt_num = 16'd1; gap = 8'd0; start = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    repeat (4) @(negedge ACLK);
    chk("abort_pre_data", m_axis_tdata, 32'h404);
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("abort_valid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_last", 32'(m_axis_tlast), 32'd0);
    chk("abort_data", m_axis_tdata, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    ARESETn = 1'b1;
    done_seen = 0;
    valid_seen = 0;
    repeat (5) begin
      @(negedge ACLK);
      if (done) done_seen++;
      if (m_axis_tvalid) valid_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_no_valid", 32'(valid_seen), 32'd0);
    $display("abort: done_seen=%0d valid_seen=%0d", done_seen, valid_seen);
    run_vec(8, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
